event_sync_ctrl: RTL
====================

// Module: event_sync_ctrl
// PURPOSE
//  Race-free event scheduler. It serialises trigger requests from N_SRC sources onto one shared
//  broadcast event. Round-robin arbitration picks the next source. Each broadcast holds until
//  every subscribed waiter acks, so no waiter misses an event through same-cycle ordering.
//  It is the synthesizable counterpart of persistent (.triggered) / non-blocking (->>) event
//  semantics, and sits between trigger producers and waiter FSMs.
// PARAMETERS
//  N_SRC    4   number of trigger sources (2..16)
//  N_WAIT   4   number of waiters (1..32)
//  TIMEOUT  16  broadcast watchdog limit in cycles; used only with EVENT_SYNC_TIMEOUT_EN
// PORTS
//  clk        in   1               clock; all logic on posedge
//  rst        in   1               synchronous reset, active-high
//  trig_i     in   N_SRC           per-source trigger; each cycle high = one request
//  sub_mask_i in   N_WAIT          waiters that must ack; sampled at grant
//  wait_ack_i in   N_WAIT          waiter acknowledge; level or pulse
//  ev_valid_o out  1               broadcast active; persistent until all acks are in
//  ev_src_o   out  $clog2(N_SRC)   source id of the current broadcast
//  ev_seq_o   out  SEQ_W           count of completed broadcasts; wraps 255->0
//  pend_o     out  N_SRC           pending (not yet granted) triggers
//  busy_o     out  1               FSM not in IDLE
//  drop_o     out  1               1-cycle pulse: trigger coalesced into an already-set pend bit
//  timeout_o  out  1               1-cycle pulse: broadcast aborted by watchdog
// BEHAVIOUR
//  Reset: all outputs 0, pend=0, rr_ptr=0, FSM=IDLE, ack_got=0, seq=0.
//  Pending: pend[i] <= pend[i] | trig_i[i], except a bit cleared by a grant in the same cycle.
//    trig_i[i] while pend[i]=1 -> drop_o=1 the next cycle. One event results; the request is coalesced.
//  FSM states: IDLE, BCAST.
//  IDLE: if pend!=0, grant the first set bit at or after rr_ptr (wrapping).
//    On grant: ev_src<=id, ack_need<=sub_mask_i, ack_got<=0, pend[id]<=0, -> BCAST.
//  BCAST: ev_valid_o=1. ack_got |= wait_ack_i & ack_need.
//    Done when (ack_got | (wait_ack_i & ack_need)) == ack_need; an empty mask completes in its first cycle.
//    On done: seq<=seq+1, rr_ptr<=ev_src+1 mod N_SRC, -> IDLE.
//  Latency: trig_i at cycle t -> pend_o at t+1 -> ev_valid_o at t+2.
//    Minimum spacing is 2 cycles per event (one BCAST cycle plus one IDLE cycle).
//  Acks are counted once per waiter. Acks outside ack_need and acks in IDLE are ignored.
//  A retrigger of ev_src during its own BCAST sets pend again, giving a new, separate event
//    (->> semantics). It does not assert drop_o.
//  sub_mask_i changes during BCAST have no effect until the next grant.
//  Reset mid-BCAST: the broadcast is abandoned, ev_valid_o=0 next cycle, and no seq increment.
// CONFIGURATION
//  `EVENT_SYNC_TIMEOUT_EN defined:
//    A cycle counter runs in BCAST. If the broadcast is not done on its TIMEOUT-th cycle,
//    timeout_o pulses and the FSM goes to IDLE. seq increments and rr_ptr advances as on done.
//  `EVENT_SYNC_TIMEOUT_EN undefined:
//    No counter. BCAST waits indefinitely. timeout_o is tied 0.
// STRUCTURE
//  event_sync_pkg: state_e {IDLE,BCAST}, SEQ_W=8, function rr_pick(pend, ptr).
//  Sub-module rr_arbiter #(N): inputs req and ptr; outputs gnt_valid and gnt_id (combinational).
//    Instantiated once.
// TESTING
//  1. Drive trig_i=0100 for 1 cycle with mask=0011, ack0 at BCAST+1 and ack1 at BCAST+3.
//     -> ev_valid_o high for 4 cycles, ev_src_o=2, ev_seq_o 0->1.
//  2. After reset, drive trig_i=1111 for 1 cycle with mask=0.
//     -> ev_src_o sequence is 0,1,2,3, each 1 BCAST cycle apart by 2 cycles, final ev_seq_o=4.
//  3. Retrigger src1 while pend[1]=1.
//     -> drop_o pulse, single event. Retrigger src1 during its BCAST -> second event, no drop_o.
//  4. Assert rst in the 2nd BCAST cycle with ev_seq_o=3.
//     -> next cycle ev_valid_o=0, pend_o=0, ev_seq_o=0, busy_o=0.
//  5. Mask=0001, no ack, TIMEOUT=16.
//     -> with the macro: timeout_o pulses on BCAST cycle 16 and ev_valid_o drops.
//     -> without the macro: ev_valid_o stays high for 100 cycles.
//  6. Ack waiter2 in IDLE with mask=0001 during BCAST.
//     -> broadcast does not complete until ack0 arrives.

Source files
------------

// File: rtl/event_sync_pkg.sv
// Shared types, widths and the round-robin pick helper for event_sync_ctrl.
package event_sync_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BCAST = 1'b1
  } state_e;

  localparam int unsigned SEQ_W    = 8;
  localparam int unsigned MAX_SRC  = 16;
  localparam int unsigned MAX_ID_W = 4;

  // Returns {found, id}: first set bit of pend at or after ptr, wrapping at n.
  function automatic logic [MAX_ID_W:0] rr_pick(input logic [MAX_SRC-1:0]  pend,
                                                 input logic [MAX_ID_W-1:0] ptr,
                                                 input int unsigned         n);
    logic [MAX_ID_W:0] res;
    int unsigned       idx;
    res = '0;
    for (int unsigned k = 0; k < MAX_SRC; k++) begin
      idx = {28'd0, ptr} + k;
      if (idx >= n) begin
        idx = idx - n;
      end
      if ((k < n) && !res[MAX_ID_W] && pend[idx[MAX_ID_W-1:0]]) begin
        res = {1'b1, idx[MAX_ID_W-1:0]};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/event_sync_ctrl_if.sv
// Trigger, subscription, ack and broadcast signals between producers, waiters and the scheduler.
interface event_sync_ctrl_if #(
  parameter int unsigned N_SRC  = 4,
  parameter int unsigned N_WAIT = 4
);
  import event_sync_pkg::*;

  localparam int unsigned IdW = $clog2(N_SRC);

  logic [N_SRC-1:0]  trig_i;
  logic [N_WAIT-1:0] sub_mask_i;
  logic [N_WAIT-1:0] wait_ack_i;
  logic              ev_valid_o;
  logic [IdW-1:0]    ev_src_o;
  logic [SEQ_W-1:0]  ev_seq_o;
  logic [N_SRC-1:0]  pend_o;
  logic              busy_o;
  logic              drop_o;
  logic              timeout_o;

  modport master (
    output trig_i, sub_mask_i, wait_ack_i,
    input  ev_valid_o, ev_src_o, ev_seq_o, pend_o, busy_o, drop_o, timeout_o
  );

  modport slave (
    input  trig_i, sub_mask_i, wait_ack_i,
    output ev_valid_o, ev_src_o, ev_seq_o, pend_o, busy_o, drop_o, timeout_o
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr, wrapping.
module rr_arbiter
  import event_sync_pkg::*;
#(
  parameter  int unsigned N   = 4,
  localparam int unsigned IdW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IdW-1:0] ptr,
  output logic           gnt_valid,
  output logic [IdW-1:0] gnt_id
);

  logic [MAX_SRC-1:0]  req_ext;
  logic [MAX_ID_W-1:0] ptr_ext;
  logic [MAX_ID_W:0]   pick;

  always_comb begin
    req_ext             = '0;
    req_ext[N-1:0]      = req;
    ptr_ext             = '0;
    ptr_ext[IdW-1:0]    = ptr;
    pick                = rr_pick(req_ext, ptr_ext, N);
  end

  assign gnt_valid = pick[MAX_ID_W];
  assign gnt_id    = IdW'(pick[MAX_ID_W-1:0]);

endmodule

// File: rtl/event_sync_ctrl.sv
// Serialises trigger requests onto one broadcast event held until all subscribed waiters ack.
// Optional broadcast watchdog enabled by defining EVENT_SYNC_TIMEOUT_EN.
module event_sync_ctrl
  import event_sync_pkg::*;
#(
  parameter int unsigned N_SRC   = 4,
  parameter int unsigned N_WAIT  = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input logic             clk,
  input logic             rst,
  event_sync_ctrl_if.slave bus
);

  localparam int unsigned    IdW    = $clog2(N_SRC);
  localparam logic [IdW-1:0] LastId = IdW'(N_SRC - 1);

  state_e            state_q, state_d;
  logic [N_SRC-1:0]  pend_q, pend_d;
  logic [IdW-1:0]    rr_ptr_q;
  logic [IdW-1:0]    ev_src_q;
  logic [N_WAIT-1:0] ack_need_q;
  logic [N_WAIT-1:0] ack_got_q;
  logic [N_WAIT-1:0] ack_now;
  logic [SEQ_W-1:0]  seq_q;
  logic              drop_q;

  logic              gnt_valid;
  logic [IdW-1:0]    gnt_id;
  logic              grant;
  logic              done;
  logic              timeout;
  logic              bcast_end;

  rr_arbiter #(
    .N(N_SRC)
  ) u_arb (
    .req      (pend_q),
    .ptr      (rr_ptr_q),
    .gnt_valid(gnt_valid),
    .gnt_id   (gnt_id)
  );

  assign ack_now = bus.wait_ack_i & ack_need_q;
  assign grant   = (state_q == IDLE) && gnt_valid;
  // Same-cycle acks count, so an empty mask or a final ack completes without an extra cycle.
  assign done    = (state_q == BCAST) && ((ack_got_q | ack_now) == ack_need_q);

`ifdef EVENT_SYNC_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] cnt_q;

  assign timeout = (state_q == BCAST) && !done && (cnt_q == CntW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || grant) begin
      cnt_q <= '0;
    end else if (state_q == BCAST) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout        = 1'b0;
`endif

  assign bcast_end = done || timeout;

  // A grant clears the winner's bit even if it retriggers that cycle; that retrigger coalesces.
  always_comb begin
    pend_d = pend_q | bus.trig_i;
    if (grant) begin
      pend_d[gnt_id] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (gnt_valid) state_d = BCAST;
      BCAST:   if (bcast_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.ev_valid_o = (state_q == BCAST);
    bus.busy_o     = (state_q != IDLE);
    bus.timeout_o  = timeout;
    bus.ev_src_o   = ev_src_q;
    bus.ev_seq_o   = seq_q;
    bus.pend_o     = pend_q;
    bus.drop_o     = drop_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q     <= '0;
      rr_ptr_q   <= '0;
      ev_src_q   <= '0;
      ack_need_q <= '0;
      ack_got_q  <= '0;
      seq_q      <= '0;
      drop_q     <= 1'b0;
    end else begin
      pend_q <= pend_d;
      drop_q <= |(bus.trig_i & pend_q);
      if (grant) begin
        ev_src_q   <= gnt_id;
        ack_need_q <= bus.sub_mask_i;
        ack_got_q  <= '0;
      end else if (state_q == BCAST) begin
        ack_got_q <= ack_got_q | ack_now;
        if (bcast_end) begin
          seq_q    <= seq_q + SEQ_W'(1);
          rr_ptr_q <= (ev_src_q == LastId) ? '0 : ev_src_q + IdW'(1);
        end
      end
    end
  end

endmodule
